// File: rtl/alu_bus_pkg.sv
// Shared definitions for the ALU operand/result bus: op codes, sequencer
// states, operand streaming order and result byte packing.
package alu_bus_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;  // radix-4
  localparam logic [1:0] OP_DIV = 2'b11;  // SRT-2

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BEGIN,
    ST_SEND_A,
    ST_SEND_Q,
    ST_SEND_M,
    ST_WAIT_END,
    ST_CAPT_LO,
    ST_RESP
  } seqState_e;

  // Operand streaming order on inbus after BEGIN.
  localparam int OPND_A = 0;
  localparam int OPND_Q = 1;
  localparam int OPND_M = 2;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] q;
    logic [7:0] m;
  } aluReq_t;

  // Operand byte for a given slot in the streaming order.
  function automatic logic [7:0] opndByte(aluReq_t r, int idx);
    case (idx)
      OPND_A:  return r.a;
      OPND_Q:  return r.q;
      default: return r.m;
    endcase
  endfunction

  // Result order on outbus: first byte is A (hi), second is Q (lo).
  function automatic logic [15:0] packResult(logic [7:0] hi, logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/alu_host_timeout.sv
// Clearable up-counter that flags the last allowed WAIT_END cycle.
// A TIMEOUT_CYCLES of 0 disables the flag entirely.
module alu_host_timeout #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL =
    CNT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

  logic [CNT_W-1:0] cnt;

  // Count enabled cycles; clear takes priority so each wait starts at 0.
  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (en)      cnt <= cnt + 1'b1;
  end

  assign tc = (TIMEOUT_CYCLES != 0) && en && (cnt == TC_VAL);

endmodule

// File: rtl/alu_host_sequencer.sv
// Bus master for the ALU: takes one request per handshake, pulses BEGIN,
// streams A/Q/M, waits for a two-cycle END carrying the result bytes and
// returns a 16-bit response with an error flag.
module alu_host_sequencer
  import alu_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_q,
  input  logic [7:0]  req_m,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        alu_begin,
  output logic [1:0]  alu_op_code,
  output logic [7:0]  alu_inbus,
  input  logic [7:0]  alu_outbus,
  input  logic        alu_end,
  output logic        busy
);

  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W = (TO_W < 1) ? 1 : TO_W;

  seqState_e  state, nextState;
  aluReq_t    reqReg;
  logic [7:0] hiByte;
  logic       toClr, toEn, toHit;

  // Counter is zeroed while streaming M so it reads 0 on the first wait cycle.
  assign toClr = (state == ST_SEND_M);
  assign toEn  = (state == ST_WAIT_END);

  alu_host_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) uTimeout (
    .clk  (clk),
    .reset(reset),
    .clr  (toClr),
    .en   (toEn),
    .tc   (toHit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nextState;
  end

  // Request latch, hi-byte capture and response load.
  always_ff @(posedge clk) begin
    if (reset) begin
      reqReg   <= '0;
      hiByte   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (state == ST_IDLE && req_valid)
        reqReg <= '{op: req_op, a: req_a, q: req_q, m: req_m};
      case (state)
        ST_WAIT_END: begin
          if (alu_end) begin
            hiByte <= alu_outbus;
          end else if (toHit) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        ST_CAPT_LO: begin
          // END must span two cycles; a single-cycle END is a protocol error.
          if (alu_end) begin
            rsp_data <= packResult(hiByte, alu_outbus);
            rsp_err  <= 1'b0;
          end else begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and bus outputs, all decoded from the current state.
  always_comb begin
    nextState   = state;
    req_ready   = 1'b0;
    busy        = 1'b1;
    rsp_valid   = 1'b0;
    alu_begin   = 1'b0;
    alu_op_code = 2'b00;
    alu_inbus   = 8'h00;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) nextState = ST_BEGIN;
      end
      ST_BEGIN: begin
        alu_begin   = 1'b1;
        alu_op_code = reqReg.op;
        nextState   = ST_SEND_A;
      end
      ST_SEND_A: begin
        alu_op_code = reqReg.op;
        alu_inbus   = opndByte(reqReg, OPND_A);
        nextState   = ST_SEND_Q;
      end
      ST_SEND_Q: begin
        alu_op_code = reqReg.op;
        alu_inbus   = opndByte(reqReg, OPND_Q);
        nextState   = ST_SEND_M;
      end
      ST_SEND_M: begin
        alu_op_code = reqReg.op;
        alu_inbus   = opndByte(reqReg, OPND_M);
        nextState   = ST_WAIT_END;
      end
      ST_WAIT_END: begin
        alu_op_code = reqReg.op;
        if (alu_end)    nextState = ST_CAPT_LO;
        else if (toHit) nextState = ST_RESP;
      end
      ST_CAPT_LO: begin
        alu_op_code = reqReg.op;
        nextState   = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) nextState = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_host_sequencer.sv
// Cycle-accurate bench: drives requests, plays the ALU side of the bus and
// checks every response against arithmetic computed from the request.
module tb_alu_host_sequencer;
  import alu_bus_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_a, req_q, req_m;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        alu_begin;
  logic [1:0]  alu_op_code;
  logic [7:0]  alu_inbus, alu_outbus;
  logic        alu_end;
  logic        busy;

  int nCmp = 0;
  int nErr = 0;

  alu_host_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_q(req_q), .req_m(req_m),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_begin(alu_begin), .alu_op_code(alu_op_code),
    .alu_inbus(alu_inbus), .alu_outbus(alu_outbus), .alu_end(alu_end),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // What the ALU computes: {A,Q} op M; div gives {remainder, quotient}.
  function automatic logic [15:0] refResult(logic [1:0] op, logic [7:0] a,
                                            logic [7:0] q, logic [7:0] m);
    logic [15:0] dvd;
    dvd = {a, q};
    case (op)
      OP_ADD:  return dvd + 16'(m);
      OP_SUB:  return dvd - 16'(m);
      OP_MUL:  return 16'(q) * 16'(m);
      default: return {8'(dvd % 16'(m)), 8'(dvd / 16'(m))};
    endcase
  endfunction

  function automatic aluReq_t mkReq(logic [1:0] op, logic [7:0] a, logic [7:0] q, logic [7:0] m);
    aluReq_t r;
    r.op = op; r.a = a; r.q = q; r.m = m;
    return r;
  endfunction

  // One full transaction. d = wait cycles before END, endLen = END length
  // (0 never, 1 short, 2 proper), bp = cycles of rsp_ready low.
  task automatic runOp(input aluReq_t r, input int d, input int endLen, input bit spur,
                       input int bp, input bit holdNext, input aluReq_t nxt);
    logic [7:0]  expB [3];
    logic [7:0]  cap  [3];
    logic [1:0]  capOp;
    logic [15:0] res, expData;
    logic        expErr;
    bit          timedOut;
    int          respAt;
    expB = '{r.a, r.q, r.m};
    rsp_ready = 1'b0;
    alu_end   = 1'b0;
    req_valid = 1'b1; req_op = r.op; req_a = r.a; req_q = r.q; req_m = r.m;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    tick;  // accept edge
    req_valid = 1'b0;
    req_op = 2'($urandom); req_a = 8'($urandom); req_q = 8'($urandom); req_m = 8'($urandom);
    chk("begin_t1", 32'(alu_begin), 32'd1);
    chk("op_begin", 32'(alu_op_code), 32'(r.op));
    chk("busy_begin", 32'(busy), 32'd1);
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    chk("inbus_begin", 32'(alu_inbus), 32'd0);
    capOp = alu_op_code;
    for (int i = 0; i < 3; i++) begin
      tick;
      alu_end = spur && (i == 1);  // stray END while Q is on the bus
      chk("begin_pulse", 32'(alu_begin), 32'd0);
      chk($sformatf("inbus_%0d", i), 32'(alu_inbus), 32'(expB[i]));
      chk("op_send", 32'(alu_op_code), 32'(r.op));
      cap[i] = alu_inbus;
    end
    res      = refResult(capOp, cap[0], cap[1], cap[2]);
    timedOut = (endLen == 0) || (d >= TMO);
    expErr   = timedOut || (endLen == 1);
    expData  = expErr ? 16'h0000 : refResult(r.op, r.a, r.q, r.m);
    respAt   = timedOut ? TMO : d + 2;
    for (int k = 0; k <= respAt; k++) begin
      tick;
      alu_end    = 1'b0;
      alu_outbus = 8'($urandom);
      if (endLen > 0 && k == d)     begin alu_end = 1'b1; alu_outbus = res[15:8]; end
      if (endLen > 1 && k == d + 1) begin alu_end = 1'b1; alu_outbus = res[7:0];  end
      chk("rsp_valid_timing", 32'(rsp_valid), 32'(k == respAt));
      chk("op_hold", 32'(alu_op_code), (k == respAt) ? 32'd0 : 32'(r.op));
      chk("inbus_wait", 32'(alu_inbus), 32'd0);
    end
    chk("rsp_data", 32'(rsp_data), 32'(expData));
    chk("rsp_err", 32'(rsp_err), 32'(expErr));
    chk("busy_resp", 32'(busy), 32'd1);
    chk("req_ready_resp", 32'(req_ready), 32'd0);
    if (holdNext) begin
      req_valid = 1'b1; req_op = nxt.op; req_a = nxt.a; req_q = nxt.q; req_m = nxt.m;
    end
    for (int b = 0; b < bp; b++) begin
      alu_end = 1'($urandom);  // END outside the wait window must be ignored
      tick;
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'(expData));
      chk("bp_err", 32'(rsp_err), 32'(expErr));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    alu_end   = 1'b0;
    rsp_ready = 1'b1;
    tick;  // response handshake edge
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("req_ready_after", 32'(req_ready), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    chk("rsp_data_keep", 32'(rsp_data), 32'(expData));
    chk("rsp_err_keep", 32'(rsp_err), 32'(expErr));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    aluReq_t r, n;
    int pick, dd, el;
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_q = '0; req_m = '0;
    rsp_ready = 1'b0; alu_outbus = '0; alu_end = 1'b0;
    tick; tick;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_begin", 32'(alu_begin), 32'd0);
    chk("rst_op", 32'(alu_op_code), 32'd0);
    chk("rst_inbus", 32'(alu_inbus), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick;

    // Add: END 6 cycles after M -> 0x0038
    n = mkReq(OP_ADD, 8'h00, 8'h00, 8'h00);
    runOp(mkReq(OP_ADD, 8'h00, 8'h25, 8'h13), 5, 2, 1'b0, 0, 1'b0, n);
    // Div: 100 / 7 -> rem 2, quot 14
    runOp(mkReq(OP_DIV, 8'h00, 8'h64, 8'h07), 3, 2, 1'b0, 0, 1'b0, n);
    // Back-pressure with a second request held during RESP
    n = mkReq(OP_SUB, 8'h12, 8'h34, 8'h05);
    runOp(mkReq(OP_MUL, 8'h00, 8'h0C, 8'h0B), 2, 2, 1'b0, 10, 1'b1, n);
    runOp(n, 4, 2, 1'b0, 0, 1'b0, n);
    // Timeout: END never arrives
    runOp(mkReq(OP_ADD, 8'h01, 8'h02, 8'h03), 0, 0, 1'b0, 1, 1'b0, n);
    // Short END plus a stray END during SEND_Q
    runOp(mkReq(OP_SUB, 8'h00, 8'hAB, 8'h01), 1, 1, 1'b1, 0, 1'b0, n);
    // END on the last allowed wait cycle wins over the timeout
    runOp(mkReq(OP_MUL, 8'h00, 8'hFF, 8'hFF), TMO - 1, 2, 1'b0, 0, 1'b0, n);
    // END one cycle too late: timeout already fired
    runOp(mkReq(OP_ADD, 8'h00, 8'h10, 8'h20), TMO, 2, 1'b0, 0, 1'b0, n);
    runOp(mkReq(OP_ADD, 8'h00, 8'h11, 8'h22), 0, 2, 1'b0, 0, 1'b0, n);

    // Reset while in WAIT_END
    req_valid = 1'b1; req_op = OP_MUL; req_a = 8'h00; req_q = 8'h05; req_m = 8'h06;
    tick;
    req_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_inbus", 32'(alu_inbus), 32'd0);
    chk("midrst_op", 32'(alu_op_code), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_rsp_data", 32'(rsp_data), 32'd0);
    reset = 1'b0;
    runOp(mkReq(OP_DIV, 8'h03, 8'hE8, 8'h0A), 2, 2, 1'b0, 0, 1'b0, n);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      r.op = 2'($urandom_range(0, 3));
      r.a  = 8'($urandom); r.q = 8'($urandom); r.m = 8'($urandom);
      if (r.op == OP_DIV) begin
        r.m = 8'($urandom_range(1, 255));
        r.a = 8'($urandom_range(0, int'(r.m) - 1));
      end
      pick = $urandom_range(0, 9);
      el   = (pick < 7) ? 2 : (pick < 9) ? 1 : 0;
      dd   = $urandom_range(0, 18);
      runOp(r, dd, el, 1'($urandom), $urandom_range(0, 3), 1'b0, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
